// File: rtl/cfd_cfg_pkg.sv
// rtl/cfd_cfg_pkg.sv - shared encodings, field layout and chain geometry for the CFD config block
package cfd_cfg_pkg;

   localparam int LE_BITS   = 6;
   localparam int CV_BITS   = 2;
   localparam int TP_BITS   = 3;
   localparam int MUX_BITS  = 4;
   localparam int CH_BITS   = LE_BITS + CV_BITS + TP_BITS;
   localparam int CHAIN_LEN = 176;

   // Bit offsets of each field inside one 11-bit channel slice.
   localparam int TP_LSB = 0;
   localparam int CV_LSB = TP_LSB + TP_BITS;
   localparam int LE_LSB = CV_LSB + CV_BITS;

   typedef enum logic [2:0] {
      MODE_LE_DAC   = 3'd0,
      MODE_CV_DAC   = 3'd1,
      MODE_TP_MUX   = 3'd2,
      MODE_CHAN_MUX = 3'd3,
      MODE_PROG_CAP = 3'd4,
      MODE_GMODE    = 3'd5,
      MODE_RSVD6    = 3'd6,
      MODE_RSVD7    = 3'd7
   } cfd_mode_e;

   typedef enum logic [2:0] {
      TP_ZC_OUT     = 3'd0,
      TP_AGND       = 3'd1,
      TP_LE_OUT     = 3'd2,
      TP_ZCP        = 3'd3,
      TP_ZCM        = 3'd4,
      TP_CV_OUT     = 3'd5,
      TP_LE_VTH     = 3'd6,
      TP_LE_NOWLIN  = 3'd7
   } cfd_tp_e;

   function automatic int chan_lsb(input int chan);
      return chan * CH_BITS;
   endfunction

endpackage

// File: rtl/cfd_sync_edge.sv
// rtl/cfd_sync_edge.sv - two-flop synchronizer with single-cycle rising-edge pulse
module cfd_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic prev;
   logic vld1;
   logic vld2;
   logic armed;

   // The detector only arms after a genuine low has passed through the
   // synchronizer, so a level held high across reset release never fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         vld1  <= 1'b0;
         vld2  <= 1'b0;
         armed <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         prev  <= sync2;
         vld1  <= 1'b1;
         vld2  <= vld1;
         armed <= armed | (vld2 & ~sync2);
      end
   end

   assign pulse = sync2 & ~prev & armed;

endmodule

// File: rtl/cfd_config_regs.sv
// rtl/cfd_config_regs.sv - per-channel CFD configuration chain with strobe writes and serial shift
// Optional serial readback (SO_CLK rotate, SO output) is built when CFD_CFG_READBACK_EN is defined.
module cfd_config_regs
   import cfd_cfg_pkg::*;
#(
   parameter int CHANNELS = 16,
   parameter int ADDRBITS = 4,
   parameter int DATABITS = 6,
   parameter int MODEBITS = 3
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [ADDRBITS-1:0]          ADDR,
   input  logic [DATABITS-1:0]          DATA,
   input  logic [MODEBITS-1:0]          MODE,
   input  logic                         STB,
   input  logic                         SI_CLK,
   input  logic                         SI,
   input  logic                         SO_CLK,
   output logic                         SO,
   output logic [CHANNELS*LE_BITS-1:0]  LE_DAC,
   output logic [CHANNELS*CV_BITS-1:0]  CV_DAC,
   output logic [CHANNELS*TP_BITS-1:0]  TP_MUX,
   output logic [MUX_BITS-1:0]          CHAN_MUX,
   output logic [MUX_BITS-1:0]          PROG_CAP,
   output logic                         GMODE,
   output logic                         COLLIDE
);

   localparam int CHAIN = CHANNELS * CH_BITS;

   logic [CHAIN-1:0]    chain;
   logic [CHANNELS-1:0] sel;
   logic                stb_pulse;
   logic                si_pulse;
   logic                so_pulse;
   cfd_mode_e           mode;

   assign mode = cfd_mode_e'(MODE);

   cfd_sync_edge u_stb_sync (
      .clk   (CLK),
      .rst   (RST),
      .din   (STB),
      .pulse (stb_pulse)
   );

   cfd_sync_edge u_si_sync (
      .clk   (CLK),
      .rst   (RST),
      .din   (SI_CLK),
      .pulse (si_pulse)
   );

`ifdef CFD_CFG_READBACK_EN
   cfd_sync_edge u_so_sync (
      .clk   (CLK),
      .rst   (RST),
      .din   (SO_CLK),
      .pulse (so_pulse)
   );

   assign SO = chain[CHAIN-1];
`else
   logic unused_so_clk;

   assign unused_so_clk = SO_CLK;
   assign so_pulse      = 1'b0;
   assign SO            = 1'b0;
`endif

   // Broadcast mode targets every channel; otherwise only the addressed one.
   always_comb begin
      sel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         sel[c] = GMODE || (int'(ADDR) == c);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         chain    <= '0;
         CHAN_MUX <= '0;
         PROG_CAP <= '0;
         GMODE    <= 1'b0;
         COLLIDE  <= 1'b0;
      end else if (stb_pulse) begin
         // A write always wins; any shift landing in the same cycle is lost.
         COLLIDE <= COLLIDE | si_pulse | so_pulse;
         case (mode)
            MODE_LE_DAC: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  if (sel[c]) begin
                     chain[chan_lsb(c) + LE_LSB +: LE_BITS] <= DATA[LE_BITS-1:0];
                  end
               end
            end
            MODE_CV_DAC: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  if (sel[c]) begin
                     chain[chan_lsb(c) + CV_LSB +: CV_BITS] <= DATA[CV_BITS-1:0];
                  end
               end
            end
            MODE_TP_MUX: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  if (sel[c]) begin
                     chain[chan_lsb(c) + TP_LSB +: TP_BITS] <= DATA[TP_BITS-1:0];
                  end
               end
            end
            MODE_CHAN_MUX: CHAN_MUX <= DATA[MUX_BITS-1:0];
            MODE_PROG_CAP: PROG_CAP <= DATA[MUX_BITS-1:0];
            MODE_GMODE:    GMODE    <= DATA[0];
            default: ;
         endcase
      end else if (si_pulse) begin
         chain <= {chain[CHAIN-2:0], SI};
      end else if (so_pulse) begin
         chain <= {chain[CHAIN-2:0], chain[CHAIN-1]};
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign LE_DAC[c*LE_BITS +: LE_BITS] = chain[c*CH_BITS + LE_LSB +: LE_BITS];
      assign CV_DAC[c*CV_BITS +: CV_BITS] = chain[c*CH_BITS + CV_LSB +: CV_BITS];
      assign TP_MUX[c*TP_BITS +: TP_BITS] = chain[c*CH_BITS + TP_LSB +: TP_BITS];
   end

endmodule
